// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enemy_pkg
// Brief    : Shared constants and types for the enemy position datapath:
//            movement modes, FSM state encoding, screen size, colour codes.
// Revision : 1.0 - initial release
// ============================================================================
package enemy_pkg;

  // Movement modes
  localparam int MODE_WRAP_L = 0;
  localparam int MODE_WRAP_R = 1;
  localparam int MODE_BOUNCE = 2;

  // Update handshake states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Screen geometry in game pixels
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // 3-bit RGB colour codes
  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

endpackage : enemy_pkg
`default_nettype wire

// File: rtl/enemy_rate_div.sv
`default_nettype none
// ============================================================================
// Module   : enemy_rate_div
// Brief    : Step-rate counter. Clear has priority over hold; while enabled
//            it counts up and wraps to zero once it has reached the terminal
//            value. The tick uses >= so a terminal value lowered below the
//            current count still fires on the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_rate_div #(
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] term_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = (cnt_q >= term_i);

  // Next count: clear, then hold, then count/wrap when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : enemy_rate_div
`default_nettype wire

// File: rtl/enemy_mover.sv
`default_nettype none
// ============================================================================
// Module   : enemy_mover
// Brief    : Horizontal enemy position datapath with wrap-left, wrap-right
//            and bounce modes, selectable speed, freeze and a four-phase
//            update_req/done handshake towards the game-control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_mover
  import enemy_pkg::*;
#(
  parameter int         START_X     = 110,
  parameter int         START_Y     = 60,
  parameter int         LEFT_LIMIT  = 0,
  parameter int         RIGHT_LIMIT = 159,
  parameter int         DIV_BASE    = 250000,
  parameter int         DIV_W       = 18,
  parameter int         STEP        = 1,
  parameter int         MODE        = 0,
  parameter logic [2:0] COLOUR      = COL_RED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update_req,
  input  logic       restart,
  input  logic       freeze,
  input  logic [1:0] speed,
  output logic [2:0] enemy_colour,
  output logic       done,
  output logic [7:0] enemy_x,
  output logic [6:0] enemy_y,
  output logic       dir_right,
  output logic       wrapped
);

  localparam logic [7:0]       c_START_X  = 8'(START_X);
  localparam logic [6:0]       c_START_Y  = 7'(START_Y);
  localparam logic [7:0]       c_LEFT     = 8'(LEFT_LIMIT);
  localparam logic [7:0]       c_RIGHT    = 8'(RIGHT_LIMIT);
  localparam logic [7:0]       c_STEP     = 8'(STEP);
  localparam logic [8:0]       c_LEFT9    = 9'(LEFT_LIMIT);
  localparam logic [8:0]       c_RIGHT9   = 9'(RIGHT_LIMIT);
  localparam logic [8:0]       c_STEP9    = 9'(STEP);
  localparam logic [DIV_W-1:0] c_DIV_BASE = DIV_W'(DIV_BASE);
  localparam logic             c_DIR_INIT = (MODE == MODE_WRAP_R);
  localparam logic             c_BOUNCE   = (MODE == MODE_BOUNCE);

  state_t           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic             dir_q, dir_d;
  logic             wrapped_q, wrapped_d;
  logic             done_q, done_d;

  logic [DIV_W-1:0] w_term;
  logic             w_tick;
  logic             w_clr;
  logic             w_hold;
  logic             w_en;

  logic             w_move_right;
  logic [8:0]       w_x9;
  logic [7:0]       w_next_x;
  logic             w_next_dir;
  logic             w_edge_hit;

  // Faster speeds shorten the divider period by powers of two
  assign w_term = c_DIV_BASE >> speed;

  enemy_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (w_clr),
    .hold_i (w_hold),
    .en_i   (w_en),
    .term_i (w_term),
    .tick_o (w_tick)
  );

  // Candidate position for the next step; 9-bit compares avoid underflow
  always_comb begin
    w_x9         = {1'b0, x_q};
    w_move_right = (MODE == MODE_WRAP_R) || (c_BOUNCE && dir_q);
    w_next_x     = x_q;
    w_next_dir   = dir_q;
    w_edge_hit   = 1'b0;
    if (w_move_right) begin
      if ((w_x9 + c_STEP9) > c_RIGHT9) begin
        w_edge_hit = 1'b1;
        if (c_BOUNCE) begin
          w_next_x   = c_RIGHT;
          w_next_dir = 1'b0;
        end else begin
          w_next_x   = c_LEFT;
        end
      end else begin
        w_next_x = x_q + c_STEP;
      end
    end else begin
      if (w_x9 < (c_LEFT9 + c_STEP9)) begin
        w_edge_hit = 1'b1;
        if (c_BOUNCE) begin
          w_next_x   = c_LEFT;
          w_next_dir = 1'b1;
        end else begin
          w_next_x   = c_RIGHT;
        end
      end else begin
        w_next_x = x_q - c_STEP;
      end
    end
  end

  // Handshake FSM: next state, step commit and divider controls
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    dir_d     = dir_q;
    wrapped_d = 1'b0;
    w_clr     = 1'b1;
    w_hold    = 1'b0;
    w_en      = 1'b0;
    if (restart) begin
      state_d = IDLE;
      x_d     = c_START_X;
      dir_d   = c_DIR_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (update_req) begin
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (!update_req) begin
            state_d = IDLE;
          end else if (freeze) begin
            w_clr  = 1'b0;
            w_hold = 1'b1;
          end else if (w_tick) begin
            x_d       = w_next_x;
            dir_d     = w_next_dir;
            wrapped_d = w_edge_hit;
            state_d   = DONE;
          end else begin
            w_clr = 1'b0;
            w_en  = 1'b1;
          end
        end
        DONE: begin
          if (!update_req) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= c_START_X;
      dir_q     <= c_DIR_INIT;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      dir_q     <= dir_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  assign enemy_colour = COLOUR;
  assign enemy_y      = c_START_Y;
  assign enemy_x      = x_q;
  assign dir_right    = dir_q;
  assign done         = done_q;
  assign wrapped      = wrapped_q;

endmodule : enemy_mover
`default_nettype wire

// File: tb/tb_enemy_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_mover
// Brief    : Scoreboard bench for enemy_mover. Instance 0 is a wrap-left
//            mover starting at 110, instance 1 a bounce mover with STEP=3
//            starting at 1. Both use DIV_BASE=8 so TERM = 8 >> speed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_mover;

  typedef struct {
    logic [7:0] x;
    logic       dir;
    logic       wrap;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n  [2];
  logic       req    [2];
  logic       rst_s  [2];
  logic       frz_s  [2];
  logic [1:0] spd    [2];
  logic [2:0] col_w  [2];
  logic       done_w [2];
  logic [7:0] x_w    [2];
  logic [6:0] y_w    [2];
  logic       dir_w  [2];
  logic       wrp_w  [2];

  exp_t sb [2][$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enemy_mover #(
    .START_X(110), .START_Y(60), .LEFT_LIMIT(0), .RIGHT_LIMIT(159),
    .DIV_BASE(8), .DIV_W(18), .STEP(1), .MODE(0), .COLOUR(3'b100)
  ) dut_a (
    .clk(clk), .reset(rst_n[0]), .update_req(req[0]), .restart(rst_s[0]),
    .freeze(frz_s[0]), .speed(spd[0]), .enemy_colour(col_w[0]),
    .done(done_w[0]), .enemy_x(x_w[0]), .enemy_y(y_w[0]),
    .dir_right(dir_w[0]), .wrapped(wrp_w[0])
  );

  enemy_mover #(
    .START_X(1), .START_Y(60), .LEFT_LIMIT(0), .RIGHT_LIMIT(159),
    .DIV_BASE(8), .DIV_W(18), .STEP(3), .MODE(2), .COLOUR(3'b100)
  ) dut_b (
    .clk(clk), .reset(rst_n[1]), .update_req(req[1]), .restart(rst_s[1]),
    .freeze(frz_s[1]), .speed(spd[1]), .enemy_colour(col_w[1]),
    .done(done_w[1]), .enemy_x(x_w[1]), .enemy_y(y_w[1]),
    .dir_right(dir_w[1]), .wrapped(wrp_w[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue a request (called at a negedge), queue its expected result and
  // wait, bounded, for done. Optional freeze covers frz edges right after
  // the request edge, i.e. in the middle of the count.
  task automatic issue_wait(input int d, input int ex, input logic edir,
                            input logic ew, input logic [1:0] sp, input int frz);
    exp_t e;
    int   n;
    int   term;
    term   = 8 >> sp;
    spd[d] = sp;
    req[d] = 1'b1;
    e.x    = 8'(ex);
    e.dir  = edir;
    e.wrap = ew;
    e.cyc  = cyc + 1 + term + 1 + frz;
    sb[d].push_back(e);
    if (frz > 0) begin
      @(negedge clk);
      frz_s[d] = 1'b1;
      repeat (frz) @(negedge clk);
      frz_s[d] = 1'b0;
    end
    n = 0;
    while (!done_w[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done_w[d]) chk("done_timeout", 0, 1);
  endtask

  // Release the request; done must fall on the following edge
  task automatic drop(input int d);
    req[d] = 1'b0;
    @(negedge clk);
    chk("done_fall", int'(done_w[d]), 0);
  endtask

  task automatic do_step(input int d, input int ex, input logic edir,
                         input logic ew, input logic [1:0] sp, input int frz);
    issue_wait(d, ex, edir, ew, sp, frz);
    drop(d);
  endtask

  // Monitor: on each done rising edge pop and compare; one cycle later
  // wrapped must be back to zero
  initial begin
    logic pdone [2];
    logic wchk  [2];
    exp_t e;
    pdone[0] = 1'b0; pdone[1] = 1'b0;
    wchk[0]  = 1'b0; wchk[1]  = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (wchk[d]) begin
          chk("wrapped_len", int'(wrp_w[d]), 0);
          wchk[d] = 1'b0;
        end
        if (done_w[d] && !pdone[d]) begin
          if (sb[d].size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb[d].pop_front();
            chk("step_x",   int'(x_w[d]),   int'(e.x));
            chk("step_y",   int'(y_w[d]),   60);
            chk("step_dir", int'(dir_w[d]), int'(e.dir));
            chk("step_wrap", int'(wrp_w[d]), int'(e.wrap));
            chk("step_latency", cyc, e.cyc);
            wchk[d] = 1'b1;
          end
        end
        pdone[d] = done_w[d];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; rst_s[d] = 1'b0;
      frz_s[d] = 1'b0; spd[d] = 2'd0;
    end
    repeat (2) @(negedge clk);
    chk("rst_a_x",    int'(x_w[0]),    110);
    chk("rst_a_y",    int'(y_w[0]),    60);
    chk("rst_a_done", int'(done_w[0]), 0);
    chk("rst_a_wrap", int'(wrp_w[0]),  0);
    chk("rst_a_dir",  int'(dir_w[0]),  0);
    chk("rst_a_col",  int'(col_w[0]),  4);
    chk("rst_b_x",    int'(x_w[1]),    1);
    chk("rst_b_dir",  int'(dir_w[1]),  0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // Basic step at TERM=8, then freeze for 5 cycles at TERM=2
    do_step(0, 109, 1'b0, 1'b0, 2'd0, 0);
    do_step(0, 108, 1'b0, 1'b0, 2'd2, 5);

    // Abort before TERM: no step, then a full-length step follows
    spd[0] = 2'd0;
    req[0] = 1'b1;
    repeat (4) @(negedge clk);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_x",    int'(x_w[0]),    108);
    chk("abort_done", int'(done_w[0]), 0);
    do_step(0, 107, 1'b0, 1'b0, 2'd0, 0);

    // Restart during COUNT
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    chk("rs_count_x",    int'(x_w[0]),    110);
    chk("rs_count_y",    int'(y_w[0]),    60);
    chk("rs_count_done", int'(done_w[0]), 0);
    rst_s[0] = 1'b0;
    req[0]   = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-count
    do_step(0, 109, 1'b0, 1'b0, 2'd3, 0);
    spd[0] = 2'd0;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("arst_x",    int'(x_w[0]),    110);
    chk("arst_y",    int'(y_w[0]),    60);
    chk("arst_done", int'(done_w[0]), 0);
    @(negedge clk);
    req[0]   = 1'b0;
    rst_n[0] = 1'b1;
    @(negedge clk);

    // Restart while in DONE
    issue_wait(0, 109, 1'b0, 1'b0, 2'd3, 0);
    rst_s[0] = 1'b1;
    @(negedge clk);
    chk("rs_done_x",    int'(x_w[0]),    110);
    chk("rs_done_done", int'(done_w[0]), 0);
    rst_s[0] = 1'b0;
    req[0]   = 1'b0;
    @(negedge clk);

    // Walk left to the limit, then wrap to the right edge
    for (int k = 109; k >= 0; k--) begin
      do_step(0, k, 1'b0, 1'b0, 2'd3, 0);
    end
    do_step(0, 159, 1'b0, 1'b1, 2'd3, 0);
    do_step(0, 158, 1'b0, 1'b0, 2'd3, 0);

    // Bounce instance: left bounce at x=1, run to the right edge, bounce back
    do_step(1, 0, 1'b1, 1'b1, 2'd3, 0);
    do_step(1, 3, 1'b1, 1'b0, 2'd3, 0);
    for (int k = 6; k <= 159; k += 3) begin
      do_step(1, k, 1'b1, 1'b0, 2'd3, 0);
    end
    do_step(1, 159, 1'b0, 1'b1, 2'd3, 0);
    do_step(1, 156, 1'b0, 1'b0, 2'd3, 0);

    repeat (3) @(negedge clk);
    chk("sb_a_empty", sb[0].size(), 0);
    chk("sb_b_empty", sb[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_enemy_mover
`default_nettype wire
